zigzag_stream: RTL

Streaming forward zigzag scanner for the JPEG-style coefficient path. It accepts 8x8 blocks of Q(15,16) coefficients in raster order, one word per cycle, and re-emits each block in zigzag order with a valid/ready handshake. It sits between the quantiser and the entropy-coding stage. It is the transmit-side counterpart of the parallel inverse-zigzag block on the decode path. A ping-pong buffer of two 64-word banks allows one block to be written while the previous block is read out.

---
 rtl/zigzag_pkg.sv | 19 +
 rtl/zigzag_lut.sv | 9 +
 rtl/zigzag_stream.sv | 68 ++++++
 3 files changed

// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared block geometry and the zigzag-to-raster table for the
// forward scanner and the decode-side reference model.
package zigzag_pkg;
    localparam int BLK_N = 64;
    localparam int IDX_W = 6;
    localparam logic [IDX_W-1:0] ZZ_TAB [BLK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    function automatic logic [IDX_W-1:0] zz_raster(input logic [IDX_W-1:0] idx);
        return ZZ_TAB[idx];
    endfunction
endpackage

// File: rtl/zigzag_lut.sv
// zigzag_lut: combinational zigzag position to raster address.
module zigzag_lut
    import zigzag_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] addr
);
    assign addr = zz_raster(idx);
endmodule

// File: rtl/zigzag_stream.sv
// zigzag_stream: ping-pong buffered raster-to-zigzag reorder of 8x8 blocks
// with valid/ready on both sides.
module zigzag_stream
    import zigzag_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx
);
    logic [DATA_W-1:0] mem [2][BLK_N];
    logic [1:0]        full;
    logic              wr_bank, rd_bank, wr_en, ld;
    logic [IDX_W-1:0]  wr_cnt, rd_cnt, rd_addr;

    zigzag_lut u_lut (.idx(rd_cnt), .addr(rd_addr));

    assign in_ready = ~full[wr_bank];
    assign wr_en    = in_valid & in_ready;
    assign ld       = full[rd_bank] & (~out_valid | out_ready);

    always_ff @(posedge clk)
        if (wr_en) mem[wr_bank][wr_cnt] <= in_data;

    // set and clear always target different banks, so both may land on one edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (&wr_cnt) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (ld) begin
                out_data  <= mem[rd_bank][rd_addr];
                out_idx   <= rd_cnt;
                out_last  <= &rd_cnt;
                out_valid <= 1'b1;
                rd_cnt    <= rd_cnt + 1'b1;
                if (&rd_cnt) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
